bfly_pipe_fxp: RTL and testbench



---
 rtl/bfly_pipe_fxp.sv | 187 ++++++++++++++++++
 tb/tb_bfly_pipe_fxp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_pipe_fxp.sv
// rtl/bfly_pipe_fxp.sv - 3-stage pipelined fixed-point radix-2 DIT butterfly with valid/ready
// Optional sticky saturation flag (o_ovf/i_ovf_clr) when BFLY_OVF_FLAG_EN is defined.
module bfly_pipe_fxp #(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 14,
    parameter int TAG_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_0_re,
    input  logic [DATA_W-1:0] i_data_0_im,
    input  logic [DATA_W-1:0] i_data_1_re,
    input  logic [DATA_W-1:0] i_data_1_im,
    input  logic [TW_W-1:0]   i_twiddle_re,
    input  logic [TW_W-1:0]   i_twiddle_im,
    input  logic              i_scale,
    input  logic              i_conj,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_0_re,
    output logic [DATA_W-1:0] o_data_0_im,
    output logic [DATA_W-1:0] o_data_1_re,
    output logic [DATA_W-1:0] o_data_1_im,
`ifdef BFLY_OVF_FLAG_EN
    output logic              o_ovf,
    input  logic              i_ovf_clr,
`endif
    output logic [TAG_W-1:0]  o_tag
);

    // Products carry one extra bit so conj(-2^(TW_W-1)) stays exact.
    localparam int PW = DATA_W + TW_W + 1;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (TW_FRAC - 1);
    localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    function automatic logic signed [SW-1:0] scale_sum(input logic signed [SW-1:0] x,
                                                       input logic sc);
        return sc ? ((x + SW'(1)) >>> 1) : x;
    endfunction

    function automatic logic [DATA_W-1:0] clip(input logic signed [SW-1:0] x);
        if (x > MAXV)
            return MAXV[DATA_W-1:0];
        else if (x < MINV)
            return MINV[DATA_W-1:0];
        else
            return x[DATA_W-1:0];
    endfunction

    logic advance;

    logic                     v1_d, v1_q, sc1_d, sc1_q;
    logic signed [DATA_W-1:0] a_re1_d, a_re1_q, a_im1_d, a_im1_q;
    logic signed [PW-1:0]     p_rr1_d, p_rr1_q, p_ii1_d, p_ii1_q;
    logic signed [PW-1:0]     p_ri1_d, p_ri1_q, p_ir1_d, p_ir1_q;
    logic [TAG_W-1:0]         tag1_d, tag1_q;

    logic                     v2_d, v2_q, sc2_d, sc2_q;
    logic signed [SW-1:0]     s0_re2_d, s0_re2_q, s0_im2_d, s0_im2_q;
    logic signed [SW-1:0]     s1_re2_d, s1_re2_q, s1_im2_d, s1_im2_q;
    logic [TAG_W-1:0]         tag2_d, tag2_q;

    logic                     v3_d, v3_q;
    logic [DATA_W-1:0]        y0_re_d, y0_re_q, y0_im_d, y0_im_q;
    logic [DATA_W-1:0]        y1_re_d, y1_re_q, y1_im_d, y1_im_q;
    logic [TAG_W-1:0]         tag3_d, tag3_q;

    logic signed [TW_W:0]     w_re_x, w_im_x;
    logic signed [SW-1:0]     t_re, t_im;
    logic signed [SW-1:0]     z0_re, z0_im, z1_re, z1_im;

    assign advance = !v3_q || i_ready;
    assign o_ready = advance;

    always_comb begin
        w_re_x = (TW_W+1)'($signed(i_twiddle_re));
        w_im_x = (TW_W+1)'($signed(i_twiddle_im));
        if (i_conj)
            w_im_x = -w_im_x;

        t_re = (SW'(p_rr1_q) - SW'(p_ii1_q) + RND) >>> TW_FRAC;
        t_im = (SW'(p_ri1_q) + SW'(p_ir1_q) + RND) >>> TW_FRAC;

        z0_re = scale_sum(s0_re2_q, sc2_q);
        z0_im = scale_sum(s0_im2_q, sc2_q);
        z1_re = scale_sum(s1_re2_q, sc2_q);
        z1_im = scale_sum(s1_im2_q, sc2_q);

        v1_d = v1_q;  sc1_d = sc1_q;  tag1_d = tag1_q;
        a_re1_d = a_re1_q;  a_im1_d = a_im1_q;
        p_rr1_d = p_rr1_q;  p_ii1_d = p_ii1_q;  p_ri1_d = p_ri1_q;  p_ir1_d = p_ir1_q;
        v2_d = v2_q;  sc2_d = sc2_q;  tag2_d = tag2_q;
        s0_re2_d = s0_re2_q;  s0_im2_d = s0_im2_q;  s1_re2_d = s1_re2_q;  s1_im2_d = s1_im2_q;
        v3_d = v3_q;  tag3_d = tag3_q;
        y0_re_d = y0_re_q;  y0_im_d = y0_im_q;  y1_re_d = y1_re_q;  y1_im_d = y1_im_q;

        // Whole pipe moves in lockstep; bubbles travel with the data.
        if (advance) begin
            v1_d    = i_valid;
            sc1_d   = i_scale;
            tag1_d  = i_tag;
            a_re1_d = $signed(i_data_0_re);
            a_im1_d = $signed(i_data_0_im);
            p_rr1_d = PW'($signed(i_data_1_re)) * PW'(w_re_x);
            p_ii1_d = PW'($signed(i_data_1_im)) * PW'(w_im_x);
            p_ri1_d = PW'($signed(i_data_1_re)) * PW'(w_im_x);
            p_ir1_d = PW'($signed(i_data_1_im)) * PW'(w_re_x);

            v2_d     = v1_q;
            sc2_d    = sc1_q;
            tag2_d   = tag1_q;
            s0_re2_d = SW'(a_re1_q) + t_re;
            s0_im2_d = SW'(a_im1_q) + t_im;
            s1_re2_d = SW'(a_re1_q) - t_re;
            s1_im2_d = SW'(a_im1_q) - t_im;

            v3_d    = v2_q;
            tag3_d  = tag2_q;
            y0_re_d = clip(z0_re);
            y0_im_d = clip(z0_im);
            y1_re_d = clip(z1_re);
            y1_im_d = clip(z1_im);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;  sc1_q <= 1'b0;  tag1_q <= '0;
            a_re1_q <= '0;  a_im1_q <= '0;
            p_rr1_q <= '0;  p_ii1_q <= '0;  p_ri1_q <= '0;  p_ir1_q <= '0;
            v2_q <= 1'b0;  sc2_q <= 1'b0;  tag2_q <= '0;
            s0_re2_q <= '0;  s0_im2_q <= '0;  s1_re2_q <= '0;  s1_im2_q <= '0;
            v3_q <= 1'b0;  tag3_q <= '0;
            y0_re_q <= '0;  y0_im_q <= '0;  y1_re_q <= '0;  y1_im_q <= '0;
        end else begin
            v1_q <= v1_d;  sc1_q <= sc1_d;  tag1_q <= tag1_d;
            a_re1_q <= a_re1_d;  a_im1_q <= a_im1_d;
            p_rr1_q <= p_rr1_d;  p_ii1_q <= p_ii1_d;  p_ri1_q <= p_ri1_d;  p_ir1_q <= p_ir1_d;
            v2_q <= v2_d;  sc2_q <= sc2_d;  tag2_q <= tag2_d;
            s0_re2_q <= s0_re2_d;  s0_im2_q <= s0_im2_d;
            s1_re2_q <= s1_re2_d;  s1_im2_q <= s1_im2_d;
            v3_q <= v3_d;  tag3_q <= tag3_d;
            y0_re_q <= y0_re_d;  y0_im_q <= y0_im_d;  y1_re_q <= y1_re_d;  y1_im_q <= y1_im_d;
        end
    end

    assign o_valid     = v3_q;
    assign o_data_0_re = y0_re_q;
    assign o_data_0_im = y0_im_q;
    assign o_data_1_re = y1_re_q;
    assign o_data_1_im = y1_im_q;
    assign o_tag       = tag3_q;

`ifdef BFLY_OVF_FLAG_EN
    function automatic logic is_sat(input logic signed [SW-1:0] x);
        return (x > MAXV) || (x < MINV);
    endfunction

    logic ovf_d, ovf_q, sat_any;

    // Set has priority over clear so a same-cycle saturation is never lost.
    always_comb begin
        sat_any = is_sat(z0_re) || is_sat(z0_im) || is_sat(z1_re) || is_sat(z1_im);
        ovf_d   = ovf_q;
        if (i_ovf_clr)
            ovf_d = 1'b0;
        if (advance && v2_q && sat_any)
            ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bfly_pipe_fxp.sv
// tb/tb_bfly_pipe_fxp.sv - scoreboard bench for bfly_pipe_fxp with directed vectors
module tb_bfly_pipe_fxp;

    typedef struct {
        logic [15:0] d0re, d0im, d1re, d1im;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, o_ready, o_valid, i_ready, i_scale, i_conj;
    logic [15:0] i_data_0_re, i_data_0_im, i_data_1_re, i_data_1_im;
    logic [15:0] i_twiddle_re, i_twiddle_im;
    logic [15:0] o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im;
    logic [3:0]  i_tag, o_tag;
`ifdef BFLY_OVF_FLAG_EN
    logic        o_ovf, i_ovf_clr;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [67:0] snap;

    always #5 clk = ~clk;

    bfly_pipe_fxp #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .TAG_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_0_re(i_data_0_re), .i_data_0_im(i_data_0_im),
        .i_data_1_re(i_data_1_re), .i_data_1_im(i_data_1_im),
        .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
        .i_scale(i_scale), .i_conj(i_conj), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data_0_re(o_data_0_re), .o_data_0_im(o_data_0_im),
        .o_data_1_re(o_data_1_re), .o_data_1_im(o_data_1_im),
`ifdef BFLY_OVF_FLAG_EN
        .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr),
`endif
        .o_tag(o_tag)
    );

    // Monitor: every output transfer is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got y0=(%0d,%0d) y1=(%0d,%0d) tag=%0d, required no output",
                         $signed(o_data_0_re), $signed(o_data_0_im),
                         $signed(o_data_1_re), $signed(o_data_1_im), o_tag);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_data_0_re !== mon_e.d0re || o_data_0_im !== mon_e.d0im ||
                    o_data_1_re !== mon_e.d1re || o_data_1_im !== mon_e.d1im || o_tag !== mon_e.tag) begin
                    n_bad++;
                    $display("FAIL output_tag%0d: got y0=(%0d,%0d) y1=(%0d,%0d) tag=%0d, required y0=(%0d,%0d) y1=(%0d,%0d) tag=%0d",
                             mon_e.tag, $signed(o_data_0_re), $signed(o_data_0_im),
                             $signed(o_data_1_re), $signed(o_data_1_im), o_tag,
                             $signed(mon_e.d0re), $signed(mon_e.d0im),
                             $signed(mon_e.d1re), $signed(mon_e.d1im), mon_e.tag);
                end
            end
        end
    end

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit sc, input bit cj, input int tg,
                        input int y0r, input int y0i, input int y1r, input int y1i);
        exp_t e;
        bit   ok = 1'b0;
        i_valid = 1'b1;
        i_data_0_re = 16'(ar);  i_data_0_im = 16'(ai);
        i_data_1_re = 16'(br);  i_data_1_im = 16'(bi);
        i_twiddle_re = 16'(wr); i_twiddle_im = 16'(wi);
        i_scale = sc;  i_conj = cj;  i_tag = 4'(tg);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.d0re = 16'(y0r);  e.d0im = 16'(y0i);
            e.d1re = 16'(y1r);  e.d1im = 16'(y1i);
            e.tag  = 4'(tg);
            sb_q.push_back(e);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout tag%0d: o_ready=%0d, required 1 within 40 cycles", tg, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            if (sb_q.size() == 0)
                break;
        end
        if (k == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;  i_valid = 1'b0;  i_ready = 1'b1;  i_scale = 1'b0;  i_conj = 1'b0;
        i_data_0_re = '0;  i_data_0_im = '0;  i_data_1_re = '0;  i_data_1_im = '0;
        i_twiddle_re = '0; i_twiddle_im = '0; i_tag = '0;
`ifdef BFLY_OVF_FLAG_EN
        i_ovf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag} !== 68'd0) begin
            n_bad++;
            $display("FAIL reset_state: o_valid=%0d o_ready=%0d out=%h, required 0 1 0",
                     o_valid, o_ready, {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(100, -50, 30, 40, 16384, 0, 0, 0, 5, 130, -10, 70, -90);
        drain();
        send(1, 1, 2, 3, 0, 16384, 0, 0, 6, -2, 3, 4, -1);
        send(1, 1, 2, 3, 0, 16384, 0, 1, 7, 4, -1, -2, 3);
        send(0, 0, 3, -3, 8192, 0, 0, 0, 8, 2, -1, -2, 1);
        send(1, 0, 0, 0, 16384, 0, 1, 0, 9, 1, 0, 1, 0);
        send(0, 0, 1, 0, 0, -32768, 0, 1, 13, 0, 2, 0, -2);
        drain();
        send(-32000, -32768, 32000, 0, 16384, 0, 0, 0, 12, 0, -32768, -32768, -32768);
        drain();
`ifdef BFLY_OVF_FLAG_EN
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
`endif
        send(32000, 0, 32000, 0, 16384, 0, 0, 0, 10, 32767, 0, 0, 0);
        drain();
`ifdef BFLY_OVF_FLAG_EN
        n_cmp++;
        if (o_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: o_ovf=%0d, required 1", o_ovf);
        end
`endif
        send(32000, 0, 32000, 0, 16384, 0, 1, 0, 11, 32000, 0, 0, 0);
        drain();
`ifdef BFLY_OVF_FLAG_EN
        n_cmp++;
        if (o_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: o_ovf=%0d, required 1", o_ovf);
        end
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
        n_cmp++;
        if (o_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: o_ovf=%0d, required 0", o_ovf);
        end
`endif

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i * 100, -i * 7, i * 3, i, 16384, 0, 0, 0, i,
                         i * 103, -i * 6, i * 97, -i * 8);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                i_ready = 1'b0;
                @(negedge clk);
                snap = {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag};
                for (int k = 0; k < 5; k++) begin
                    if (k > 0)
                        @(negedge clk);
                    n_cmp++;
                    if (o_valid !== 1'b1 || o_ready !== 1'b0 ||
                        {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag} !== snap) begin
                        n_bad++;
                        $display("FAIL stall_cycle%0d: o_valid=%0d o_ready=%0d out=%h, required 1 0 %h",
                                 k, o_valid, o_ready,
                                 {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag}, snap);
                    end
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();

        send(1, 2, 3, 4, 16384, 0, 0, 0, 1, 4, 6, -2, -2);
        send(5, 6, 7, 8, 16384, 0, 0, 0, 2, 12, 14, -2, -2);
        send(9, 10, 11, 12, 16384, 0, 0, 0, 3, 20, 22, -2, -2);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag} !== 68'd0) begin
            n_bad++;
            $display("FAIL reset_midflight: o_valid=%0d out=%h, required 0 0",
                     o_valid, {o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im, o_tag});
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int stale = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (o_valid)
                    stale++;
            end
            n_cmp++;
            if (stale != 0) begin
                n_bad++;
                $display("FAIL no_stale: %0d valid cycles after reset, required 0", stale);
            end
        end
        @(posedge clk);
        #1;
        begin
            int lat = 1;
            send(-7, 9, 2, -1, 16384, 0, 0, 0, 14, -5, 8, -9, 10);
            while (!o_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_cmp++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL latency: %0d cycles, required 3", lat);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
